// File: rtl/uart_pg_loader.sv
// UART program loader: receives an 8N1 byte stream, parses A5/LEN/data/CSUM frames
// and emits one-cycle word writes into the program RAM downloader port.
module uart_pg_loader #(
  parameter int CLK_FREQ    = 10_000_000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        pg_clk_i,
  input  logic        pg_rst_i,
  input  logic        uart_rx,
  output logic        pg_wen,
  output logic [15:0] pg_din,
  output logic [15:0] pg_adr,
  output logic        pg_done,
  output logic        pg_err,
  output logic        pg_busy
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int DW   = $clog2(DIV + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DW-1:0] DIV_C    = DW'(DIV);
  localparam logic [DW-1:0] HALF_C   = DW'(HALF);
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] ST_HUNT   = 3'd0;
  localparam logic [2:0] ST_LEN_H  = 3'd1;
  localparam logic [2:0] ST_LEN_L  = 3'd2;
  localparam logic [2:0] ST_DATA_L = 3'd3;
  localparam logic [2:0] ST_DATA_H = 3'd4;
  localparam logic [2:0] ST_CSUM   = 3'd5;

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [1:0]    rx_state;
  logic [DW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          byte_valid;
  logic          frame_err;

  logic [2:0]    state;
  logic [15:0]   len;
  logic [15:0]   word_cnt;
  logic [7:0]    lo_byte;
  logic [7:0]    csum;
  logic [TW-1:0] tmo_cnt;

  // Synchronizer history resets low so a line that is low when reset releases
  // cannot look like a start edge; it must go high and fall again first.
  always_ff @(posedge pg_clk_i) begin
    if (pg_rst_i) begin
      rx_meta    <= 1'b0;
      rx_sync    <= 1'b0;
      rx_prev    <= 1'b0;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= uart_rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= CNT_ONE;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_C) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= CNT_ONE;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_C) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_cnt   <= CNT_ONE;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_C) begin
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A byte arriving in the same cycle the timeout would expire takes priority.
  always_ff @(posedge pg_clk_i) begin
    if (pg_rst_i) begin
      state    <= ST_HUNT;
      len      <= '0;
      word_cnt <= '0;
      lo_byte  <= '0;
      csum     <= '0;
      tmo_cnt  <= '0;
      pg_wen   <= 1'b0;
      pg_din   <= '0;
      pg_adr   <= '0;
      pg_done  <= 1'b0;
      pg_err   <= 1'b0;
    end else begin
      pg_wen <= 1'b0;
      if (pg_wen) pg_adr <= pg_adr + 16'd1;
      if (frame_err) begin
        pg_err  <= 1'b1;
        state   <= ST_HUNT;
        tmo_cnt <= '0;
      end else if (byte_valid) begin
        tmo_cnt <= '0;
        case (state)
          ST_HUNT: begin
            if (rx_shift == 8'hA5) begin
              state    <= ST_LEN_H;
              pg_done  <= 1'b0;
              pg_err   <= 1'b0;
              csum     <= '0;
              pg_adr   <= '0;
              word_cnt <= '0;
            end
          end
          ST_LEN_H: begin
            len[15:8] <= rx_shift;
            state     <= ST_LEN_L;
          end
          ST_LEN_L: begin
            len[7:0] <= rx_shift;
            state    <= ({len[15:8], rx_shift} == 16'd0) ? ST_CSUM : ST_DATA_L;
          end
          ST_DATA_L: begin
            lo_byte <= rx_shift;
            csum    <= csum ^ rx_shift;
            state   <= ST_DATA_H;
          end
          ST_DATA_H: begin
            pg_wen   <= 1'b1;
            pg_din   <= {rx_shift, lo_byte};
            csum     <= csum ^ rx_shift;
            word_cnt <= word_cnt + 16'd1;
            state    <= (word_cnt + 16'd1 == len) ? ST_CSUM : ST_DATA_L;
          end
          ST_CSUM: begin
            if (rx_shift == csum) pg_done <= 1'b1;
            else                  pg_err  <= 1'b1;
            state <= ST_HUNT;
          end
          default: state <= ST_HUNT;
        endcase
      end else if (state != ST_HUNT) begin
        if (tmo_cnt == TMO_LAST) begin
          pg_err  <= 1'b1;
          state   <= ST_HUNT;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_ONE;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  assign pg_busy = (state != ST_HUNT);

endmodule

// File: tb/tb_uart_pg_loader.sv
// Randomized and directed bench for uart_pg_loader; expected writes and flags come
// from a frame parser that works directly on the transmitted byte list.
module tb_uart_pg_loader;

  localparam int DIV = 16;
  typedef logic [7:0] byte_q_t[$];

  logic        pg_clk_i = 1'b0;
  logic        pg_rst_i = 1'b1;
  logic        uart_rx  = 1'b1;
  logic        pg_wen;
  logic [15:0] pg_din;
  logic [15:0] pg_adr;
  logic        pg_done;
  logic        pg_err;
  logic        pg_busy;

  int checks   = 0;
  int failures = 0;

  logic        abort_tx = 1'b0;
  logic [31:0] got_wr[$];
  logic [31:0] exp_wr[$];
  logic        exp_done;
  logic        exp_err;
  logic [15:0] exp_adr;
  logic [15:0] exp_din;

  byte_q_t    q;
  byte_q_t    q_all;
  bit         incomplete;
  logic [7:0] b;
  logic [7:0] x;
  int         wlen;

  always #5 pg_clk_i = ~pg_clk_i;

  uart_pg_loader #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (100_000),
    .TIMEOUT_CYC(2000)
  ) dut (
    .pg_clk_i(pg_clk_i),
    .pg_rst_i(pg_rst_i),
    .uart_rx (uart_rx),
    .pg_wen  (pg_wen),
    .pg_din  (pg_din),
    .pg_adr  (pg_adr),
    .pg_done (pg_done),
    .pg_err  (pg_err),
    .pg_busy (pg_busy)
  );

  always @(negedge pg_clk_i) begin
    if (pg_wen === 1'b1) got_wr.push_back({pg_adr, pg_din});
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_val);
    logic [9:0] frame;
    frame = {stop_val, data, 1'b0};
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < DIV; c++) begin
        if (abort_tx) begin
          uart_rx = 1'b1;
          return;
        end
        uart_rx = frame[bi];
        @(negedge pg_clk_i);
      end
    end
    uart_rx = 1'b1;
  endtask

  task automatic applyStimulus(input byte_q_t bytes, input int max_gap);
    foreach (bytes[i]) begin
      send_byte(bytes[i], 1'b1);
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge pg_clk_i);
    end
  endtask

  // Frame parser: skip to each A5, read the big-endian length, pair bytes into
  // words low byte first, then compare the trailing byte with their XOR.
  task automatic model_frames(input byte_q_t bytes, output bit inc);
    int i;
    int n;
    int k;
    int flen;
    logic [7:0]  fx;
    logic [15:0] word;
    i   = 0;
    n   = bytes.size();
    inc = 1'b0;
    while (i < n) begin
      if (bytes[i] != 8'hA5) begin
        i++;
        continue;
      end
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_adr  = 16'd0;
      if (i + 2 >= n) begin
        inc = 1'b1;
        break;
      end
      flen = {16'd0, bytes[i+1], bytes[i+2]};
      fx   = 8'h00;
      for (k = 0; k < flen; k++) begin
        if (i + 4 + 2*k >= n) break;
        word = {bytes[i+4+2*k], bytes[i+3+2*k]};
        exp_wr.push_back({16'(k), word});
        exp_din = word;
        exp_adr = 16'(k + 1);
        fx      = fx ^ bytes[i+3+2*k] ^ bytes[i+4+2*k];
      end
      if (k < flen || i + 3 + 2*flen >= n) begin
        inc = 1'b1;
        break;
      end
      if (bytes[i+3+2*flen] == fx) exp_done = 1'b1;
      else                         exp_err  = 1'b1;
      i = i + 4 + 2*flen;
    end
  endtask

  task automatic compare_session(input string tag, input logic exp_busy);
    checkOutput({tag, ".nwr"}, got_wr.size(), exp_wr.size());
    foreach (exp_wr[i]) begin
      if (i < got_wr.size()) checkOutput($sformatf("%s.wr%0d", tag, i), got_wr[i], exp_wr[i]);
    end
    checkOutput({tag, ".done"}, pg_done, exp_done);
    checkOutput({tag, ".err"},  pg_err,  exp_err);
    checkOutput({tag, ".busy"}, pg_busy, exp_busy);
    checkOutput({tag, ".adr"},  pg_adr,  exp_adr);
    checkOutput({tag, ".din"},  pg_din,  exp_din);
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic run_session(input string tag, input byte_q_t bytes, input int max_gap);
    bit inc;
    applyStimulus(bytes, max_gap);
    repeat (20) @(negedge pg_clk_i);
    model_frames(bytes, inc);
    compare_session(tag, inc);
  endtask

  initial begin
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_adr  = 16'd0;
    exp_din  = 16'd0;

    repeat (5) @(negedge pg_clk_i);
    checkOutput("rst.wen",  pg_wen,  1'b0);
    checkOutput("rst.din",  pg_din,  16'd0);
    checkOutput("rst.adr",  pg_adr,  16'd0);
    checkOutput("rst.done", pg_done, 1'b0);
    checkOutput("rst.err",  pg_err,  1'b0);
    checkOutput("rst.busy", pg_busy, 1'b0);
    pg_rst_i = 1'b0;
    repeat (10) @(negedge pg_clk_i);

    q = {8'hA5, 8'h00, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    run_session("good", q, 0);
    q = {8'hA5, 8'h00, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h41};
    run_session("badsum", q, 0);
    q = {8'h3C, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
    run_session("len0", q, 0);

    // Truncated frame: still busy shortly before the timeout, aborted after it.
    q = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    applyStimulus(q, 0);
    repeat (1900) @(negedge pg_clk_i);
    checkOutput("tmo.busy_pre", pg_busy, 1'b1);
    checkOutput("tmo.err_pre",  pg_err,  1'b0);
    repeat (200) @(negedge pg_clk_i);
    model_frames(q, incomplete);
    if (incomplete) exp_err = 1'b1;
    compare_session("tmo", 1'b0);
    q = {8'hA5, 8'h00, 8'h01, 8'h78, 8'h56, 8'h2E};
    run_session("tmo.next", q, 0);

    // Framing error on the first data byte.
    q = {8'hA5, 8'h00, 8'h02};
    applyStimulus(q, 0);
    send_byte(8'h34, 1'b0);
    repeat (20) @(negedge pg_clk_i);
    exp_done = 1'b0;
    exp_err  = 1'b1;
    exp_adr  = 16'd0;
    compare_session("frm", 1'b0);

    // An 8-cycle low glitch mid-frame must not create a byte.
    q = {8'hA5, 8'h00, 8'h01};
    applyStimulus(q, 0);
    repeat (32) @(negedge pg_clk_i);
    uart_rx = 1'b0;
    repeat (8) @(negedge pg_clk_i);
    uart_rx = 1'b1;
    repeat (40) @(negedge pg_clk_i);
    q = {8'h34, 8'h12, 8'h26};
    applyStimulus(q, 0);
    repeat (20) @(negedge pg_clk_i);
    q_all = {8'hA5, 8'h00, 8'h01, 8'h34, 8'h12, 8'h26};
    model_frames(q_all, incomplete);
    compare_session("glitch", incomplete);

    // Reset pulse in the middle of the second word.
    q = {8'hA5, 8'h00, 8'h02, 8'h34, 8'h12};
    applyStimulus(q, 0);
    fork
      send_byte(8'hCD, 1'b1);
      begin
        repeat (DIV*5 + 3) @(negedge pg_clk_i);
        pg_rst_i = 1'b1;
        abort_tx = 1'b1;
        @(negedge pg_clk_i);
        pg_rst_i = 1'b0;
        checkOutput("midrst.wen",  pg_wen,  1'b0);
        checkOutput("midrst.din",  pg_din,  16'd0);
        checkOutput("midrst.adr",  pg_adr,  16'd0);
        checkOutput("midrst.done", pg_done, 1'b0);
        checkOutput("midrst.err",  pg_err,  1'b0);
        checkOutput("midrst.busy", pg_busy, 1'b0);
      end
    join
    abort_tx = 1'b0;
    uart_rx  = 1'b1;
    repeat (200) @(negedge pg_clk_i);
    exp_wr.push_back(32'h0000_1234);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_adr  = 16'd0;
    exp_din  = 16'd0;
    compare_session("midrst", 1'b0);
    q = {8'hA5, 8'h00, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    run_session("after_rst", q, 0);

    // Random sessions: junk bytes, short frames, occasional corrupted checksum.
    for (int s = 0; s < 8; s++) begin
      q.delete();
      repeat ($urandom_range(2, 0)) begin
        do b = 8'($urandom); while (b == 8'hA5);
        q.push_back(b);
      end
      repeat ($urandom_range(2, 1)) begin
        wlen = $urandom_range(3, 0);
        q.push_back(8'hA5);
        q.push_back(8'h00);
        q.push_back(8'(wlen));
        x = 8'h00;
        for (int j = 0; j < 2*wlen; j++) begin
          b = 8'($urandom);
          q.push_back(b);
          x = x ^ b;
        end
        if ($urandom_range(3, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
        q.push_back(x);
        repeat ($urandom_range(1, 0)) begin
          do b = 8'($urandom); while (b == 8'hA5);
          q.push_back(b);
        end
      end
      run_session($sformatf("rnd%0d", s), q, 20);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_pg_loader.md
UART_PG_LOADER -- requirements
Module: uart_pg_loader

Interface
REQ-001 Parameter CLK_FREQ, default 10_000_000, pg_clk_i frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; DIV = CLK_FREQ/BAUD, truncated.
REQ-003 Parameter TIMEOUT_CYC, default 1_000_000, inter-byte timeout in pg_clk_i cycles.
REQ-004 pg_clk_i  input  1  single clock; all logic rising-edge.
REQ-005 pg_rst_i  input  1  synchronous active-high reset.
REQ-006 uart_rx  input  1  asynchronous serial line, 8N1, idle high.
REQ-007 pg_wen  output  1  one-cycle write strobe to the program RAM downloader port.
REQ-008 pg_din  output  16  write data.
REQ-009 pg_adr  output  16  write word address.
REQ-010 pg_done  output  1  level; download completed with good checksum.
REQ-011 pg_err  output  1  level; last session aborted (framing, checksum, timeout).
REQ-012 pg_busy  output  1  high in any state other than HUNT.

Function
REQ-013 uart_rx passes a 2-flop synchronizer before any use.
REQ-014 Receiver: start on synced high->low; at DIV/2 cycles later, if line is high, treat as a false start and return to idle; otherwise sample 8 data bits LSB-first every DIV cycles, then the stop bit after another DIV cycles.
REQ-015 Stop bit 0 = framing error: byte discarded, pg_err=1, FSM -> HUNT.
REQ-016 A good byte produces one internal byte-valid cycle; no byte is lost at back-to-back frames.
REQ-017 Frame format: 0xA5, LEN_H, LEN_L, then LEN words each sent low byte first, then CSUM = XOR of all 2*LEN data bytes.
REQ-018 FSM states: HUNT, LEN_H, LEN_L, DATA_L, DATA_H, CSUM.
REQ-019 HUNT: only byte 0xA5 is acted upon (-> LEN_H; clear pg_done, pg_err, checksum; pg_adr=0); all other bytes are ignored.
REQ-020 LEN_H -> LEN_L -> (LEN==0 ? CSUM : DATA_L).
REQ-021 DATA_L stores the byte -> DATA_H; on DATA_H the word {hi,lo} is assembled.
REQ-022 Write cycle: pg_wen=1 for exactly one cycle, the cycle after the DATA_H byte-valid; pg_din = word and pg_adr = current address in that cycle.
REQ-023 pg_din and pg_adr hold their values until the next write; pg_adr increments by 1 in the cycle after pg_wen.
REQ-024 After the LEN-th word -> CSUM. No address wrap occurs because LEN <= 65535.
REQ-025 CSUM: byte == running XOR -> pg_done=1; otherwise pg_err=1. Either way -> HUNT.
REQ-026 pg_done stays high until reset or the next accepted 0xA5, during which the system keeps the CPU in reset.
REQ-027 Timeout: in any non-HUNT state, TIMEOUT_CYC cycles with no byte-valid -> pg_err=1, -> HUNT. The counter reloads on every byte-valid.
REQ-028 Simultaneous timeout expiry and byte-valid: the byte wins and the counter reloads.

Reset
REQ-029 While pg_rst_i=1 at a clock edge: FSM=HUNT, receiver idle, pg_wen=0, pg_din=0, pg_adr=0, pg_done=0, pg_err=0, pg_busy=0, checksum=0, timeout counter cleared.
REQ-030 Reset asserted mid-frame or mid-byte aborts without any further pg_wen; after release, the receiver resynchronizes only on a fresh start edge.
REQ-031 pg_rst_i has priority over every other event in the same cycle.

Verification (bench: CLK_FREQ=1_600_000, BAUD=100_000, DIV=16, TIMEOUT_CYC=2000)
REQ-032 Send A5 00 02 34 12 CD AB, CSUM=0x40 -> pg_wen pulses twice with (adr 0x0000, din 0x1234) and (adr 0x0001, din 0xABCD); then pg_done=1, pg_err=0.
REQ-033 Same frame with CSUM=0x41 -> both writes occur, pg_done=0, pg_err=1, pg_busy=0.
REQ-034 Send 3C 00 A5 00 00 00 -> leading bytes ignored, zero writes, pg_done=1.
REQ-035 Send A5 00 03 11 22, then idle 2100 cycles -> one write (adr 0, din 0x2211), pg_err=1, FSM=HUNT; a following good frame restarts at adr 0.
REQ-036 Byte with stop bit forced 0 during DATA_L -> pg_err=1, no pg_wen for that word; an 8-cycle low glitch on idle line -> no byte-valid.
REQ-037 pg_rst_i pulsed one cycle during the second data word of the REQ-032 frame -> all outputs 0 on the next edge, only the first write observed.
